// File: rtl/n_bit_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : n_bit_arith_pkg
//  Description : Shared constants for the arithmetic lab datapath blocks
//                (sequential divider, combinational multiplier).
//                - STATE_W / IDLE / RUN / DONE : divider FSM encoding
//                - cnt_width(n) : width of a down-counter that holds n-1
//  Revision    : 1.0  initial release
// ============================================================================
package n_bit_arith_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] IDLE = 2'd0;
    localparam logic [STATE_W-1:0] RUN  = 2'd1;
    localparam logic [STATE_W-1:0] DONE = 2'd2;

    // Width of the iteration counter.
    // It is loaded with n-1 and counts down to zero.
    // The result is floored at 1 so that a zero-width vector is never formed.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/n_bit_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : n_bit_div_step
//  Description : One combinational iteration of restoring division.
//                Shifts the next dividend bit into the partial remainder,
//                then subtracts the divisor if the subtraction does not
//                underflow.
//  Ports       : rem      [N:0]   partial remainder in
//                din              next dividend bit (msb first)
//                divisor  [N-1:0] divisor
//                rem_next [N:0]   partial remainder out
//                q_bit            quotient bit produced by this step
//  Revision    : 1.0  initial release
// ============================================================================
module n_bit_div_step #(
    parameter int N = 4
) (
    input  logic [N:0]   rem,
    input  logic         din,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_next,
    output logic         q_bit
);

    logic [N+1:0] w_shift;
    logic [N+1:0] w_diff;

    // Work one bit wider than the remainder.
    // The borrow out of the subtraction is then the sign bit, which is
    // exactly the "shifted < divisor" comparison.
    assign w_shift  = {rem, din};
    assign w_diff   = w_shift - {2'b00, divisor};
    assign q_bit    = ~w_diff[N+1];
    assign rem_next = q_bit ? w_diff[N:0] : w_shift[N:0];

endmodule
`default_nettype wire

// File: rtl/n_bit_divider.sv
`default_nettype none
// ============================================================================
//  Module      : n_bit_divider
//  Description : Sequential unsigned N-bit divider.
//                Uses restoring shift-subtract, one quotient bit per clock,
//                under a start/done handshake.
//  Ports       : clk          system clock, rising edge
//                rst_n        asynchronous active-low reset
//                start        request a division (sampled in IDLE only)
//                a   [N-1:0]  dividend, captured on the accepting edge
//                b   [N-1:0]  divisor, captured on the accepting edge
//                busy         high while iterating
//                done         one-cycle pulse; q/r/div_by_zero are valid
//                q   [N-1:0]  quotient  a / b
//                r   [N-1:0]  remainder a % b
//                div_by_zero  captured divisor was zero
//  Revision    : 1.0  initial release
// ============================================================================
module n_bit_divider
    import n_bit_arith_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         div_by_zero
);

    localparam int            CW         = cnt_width(N);
    localparam logic [CW-1:0] c_CNT_LOAD = CW'(N - 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;

    // The dividend register doubles as the quotient register.
    // Dividend bits leave at the msb while quotient bits enter at the lsb.
    logic [N-1:0]  r_dividend;
    logic [N-1:0]  r_divisor;
    logic [N:0]    r_rem;
    logic [CW-1:0] r_count;

    logic [N:0]    w_rem_next;
    logic          w_q_bit;
    logic [N-1:0]  w_q_shift;
    logic          w_last_step;

    n_bit_div_step #(
        .N (N)
    ) u_step (
        .rem      (r_rem),
        .din      (r_dividend[N-1]),
        .divisor  (r_divisor),
        .rem_next (w_rem_next),
        .q_bit    (w_q_bit)
    );

    assign w_q_shift   = {r_dividend[N-2:0], w_q_bit};
    assign w_last_step = (r_count == '0);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (w_last_step) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dividend <= a;
                        r_divisor  <= b;
                        r_rem      <= '0;
                        r_count    <= c_CNT_LOAD;
                    end
                end
                RUN: begin
                    r_rem      <= w_rem_next;
                    r_dividend <= w_q_shift;
                    r_count    <= r_count - 1'b1;
                    // The result registers load on the edge that enters
                    // DONE. They then hold until the next completion.
                    if (w_last_step) begin
                        q           <= w_q_shift;
                        r           <= w_rem_next[N-1:0];
                        div_by_zero <= (r_divisor == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_n_bit_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_n_bit_divider
//  Description : Self-checking bench for n_bit_divider.
//                Instantiates an N=4 and an N=5 divider and applies
//                directed and exhaustive vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_n_bit_divider;

    logic       clk;
    logic       rst_n;

    logic       start4, busy4, done4, dz4;
    logic [3:0] a4, b4, q4, r4;
    logic       start5, busy5, done5, dz5;
    logic [4:0] a5, b5, q5, r5;

    int errors;
    int checks;

    n_bit_divider #(.N(4)) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start4),
        .a           (a4),
        .b           (b4),
        .busy        (busy4),
        .done        (done4),
        .q           (q4),
        .r           (r4),
        .div_by_zero (dz4)
    );

    n_bit_divider #(.N(5)) u_dut5 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start5),
        .a           (a5),
        .b           (b5),
        .busy        (busy5),
        .done        (done5),
        .q           (q5),
        .r           (r5),
        .div_by_zero (dz5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic cur_done(input int w);
        return (w == 4) ? done4 : done5;
    endfunction

    function automatic logic cur_busy(input int w);
        return (w == 4) ? busy4 : busy5;
    endfunction

    // Issues one division and waits for completion.
    // It must be called at #1 after an edge, with the DUT in IDLE.
    // It returns at #1 after the DONE->IDLE edge.
    task automatic do_div(input int w, input int av, input int bv,
                          output int qv, output int rv, output int dzv,
                          output int latv, output int busyv);
        if (w == 4) begin
            a4 = av[3:0]; b4 = bv[3:0]; start4 = 1'b1;
        end else begin
            a5 = av[4:0]; b5 = bv[4:0]; start5 = 1'b1;
        end
        @(posedge clk); #1;              // accepting edge
        start4 = 1'b0; start5 = 1'b0;
        a4 = ~a4; b4 = ~b4; a5 = ~a5; b5 = ~b5;   // operands are free to change
        latv  = 0;
        busyv = 0;
        while (!cur_done(w) && latv < 20) begin
            if (cur_busy(w)) busyv++;
            @(posedge clk); #1;
            latv++;
        end
        if (w == 4) begin
            qv = int'(q4); rv = int'(r4); dzv = int'(dz4);
        end else begin
            qv = int'(q5); rv = int'(r5); dzv = int'(dz5);
        end
        @(posedge clk); #1;
        chk("done_pulse", int'(cur_done(w)), 0);
    endtask

    task automatic div_check(input int w, input int av, input int bv);
        int qv, rv, dzv, latv, busyv;
        do_div(w, av, bv, qv, rv, dzv, latv, busyv);
        chk("latency", latv, w);
        chk("busy_cycles", busyv, w);
        if (bv != 0) begin
            chk("quotient", qv, av / bv);
            chk("remainder", rv, av % bv);
            chk("round_trip", qv * bv + rv, av);
            chk("div_by_zero", dzv, 0);
        end else begin
            chk("dz_quotient", qv, (1 << w) - 1);
            chk("dz_remainder", rv, av);
            chk("div_by_zero", dzv, 1);
        end
    endtask

    initial begin
        int qv, rv, dzv, latv, busyv;
        errors = 0;
        checks = 0;
        start4 = 1'b0; start5 = 1'b0;
        a4 = '0; b4 = '0; a5 = '0; b5 = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy4), 0);
        chk("rst_done", int'(done4), 0);
        chk("rst_q", int'(q4), 0);
        chk("rst_r", int'(r4), 0);
        chk("rst_dz", int'(dz4), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors.
        // The 13/4 case is checked explicitly for the 4-edge latency and
        // the 4 busy cycles.
        do_div(4, 13, 4, qv, rv, dzv, latv, busyv);
        chk("13/4 latency", latv, 4);
        chk("13/4 busy", busyv, 4);
        chk("13/4 q", qv, 3);
        chk("13/4 r", rv, 1);
        chk("13/4 dz", dzv, 0);

        do_div(4, 7, 0, qv, rv, dzv, latv, busyv);
        chk("7/0 q", qv, 15);
        chk("7/0 r", rv, 7);
        chk("7/0 dz", dzv, 1);
        chk("7/0 latency", latv, 4);

        do_div(4, 0, 5, qv, rv, dzv, latv, busyv);
        chk("0/5 q", qv, 0);
        chk("0/5 r", rv, 0);
        chk("0/5 dz", dzv, 0);

        // Exhaustive sweeps.
        for (int av = 0; av < 16; av++)
            for (int bv = 0; bv < 16; bv++)
                div_check(4, av, bv);
        for (int av = 0; av < 32; av++)
            for (int bv = 0; bv < 32; bv++)
                div_check(5, av, bv);

        // A start raised while RUN is active must be ignored.
        a4 = 4'd15; b4 = 4'd2; start4 = 1'b1;
        @(posedge clk); #1;
        a4 = 4'd9; b4 = 4'd3;            // start is held high through RUN
        latv = 0;
        while (!done4 && latv < 20) begin
            @(posedge clk); #1;
            latv++;
        end
        start4 = 1'b0;
        chk("ignore latency", latv, 4);
        chk("ignore q", int'(q4), 7);
        chk("ignore r", int'(r4), 1);
        @(posedge clk); #1;
        chk("ignore idle", int'(busy4), 0);
        do_div(4, 9, 3, qv, rv, dzv, latv, busyv);
        chk("9/3 q", qv, 3);
        chk("9/3 r", rv, 0);

        // Asynchronous reset in the middle of a division.
        a4 = 4'd14; b4 = 4'd3; start4 = 1'b1;
        @(posedge clk); #1;              // accepting edge
        start4 = 1'b0;
        @(posedge clk); #1;              // step 1 done
        @(negedge clk);                  // mid-cycle, during step 2
        rst_n = 1'b0;
        #1;
        chk("midrst busy", int'(busy4), 0);
        chk("midrst done", int'(done4), 0);
        chk("midrst q", int'(q4), 0);
        chk("midrst r", int'(r4), 0);
        chk("midrst dz", int'(dz4), 0);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            chk("post_rst no done", int'(done4), 0);
            chk("post_rst no busy", int'(busy4), 0);
            @(posedge clk); #1;
        end
        do_div(4, 14, 3, qv, rv, dzv, latv, busyv);
        chk("14/3 q", qv, 4);
        chk("14/3 r", rv, 2);
        chk("14/3 latency", latv, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
